// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: register file, one shared bus driven by a
// priority mux of *out strobes, a combinational ALU (A = Y, B = bus) and a
// 64-bit result register Z. All transfers are strobe-driven from outside.
module datapath (
    output logic [31:0] outp,
    input  logic        PCout,
    input  logic        Zhiout,
    input  logic        Zlowout,
    input  logic        MDRout,
    input  logic        R2out,
    input  logic        R4out,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        MARin,
    input  logic        Zin,
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        IncPC,
    input  logic        Read,
    input  logic        R5in,
    input  logic        R2in,
    input  logic        R4in,
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] Mdatain,
    input  logic        AND,
    input  logic        OR,
    input  logic        ADD,
    input  logic        SUB,
    input  logic        MUL,
    input  logic        DIV,
    input  logic        SHR,
    input  logic        SHL,
    input  logic        ROR,
    input  logic        ROL,
    input  logic        NEG,
    input  logic        NOT
);

    logic [31:0] pc, ir, mar, mdr, y, hi, lo, r2, r4, r5;
    logic [63:0] z;
    logic [31:0] bus;
    logic [63:0] alu;

    // Helper terms for the ALU; kept outside the select chain for readability.
    logic [63:0] prod;
    logic [32:0] quo_ext, rem_ext;
    logic [63:0] rot_r, rot_l;
    logic [4:0]  sh;

    // IR, MAR and R5 feed circuitry outside this block and are not read here.
    logic unused_regs;
    assign unused_regs = ^{ir, mar, r5};

    // Bus source mux, fixed priority; nothing selected drives zero.
    always_comb begin
        bus = 32'd0;
        if (PCout)        bus = pc;
        else if (Zhiout)  bus = z[63:32];
        else if (Zlowout) bus = z[31:0];
        else if (MDRout)  bus = mdr;
        else if (R2out)   bus = r2;
        else if (R4out)   bus = r4;
        else if (HIout)   bus = hi;
        else if (LOout)   bus = lo;
    end

    assign outp = bus;

    // Signed product via explicit sign extension, taking the low 64 bits.
    assign prod = {{32{y[31]}}, y} * {{32{bus[31]}}, bus};
    // Divide in 33 bits so the most-negative / -1 case cannot overflow.
    assign quo_ext = (bus == 32'd0) ? 33'd0
                   : $unsigned($signed({y[31], y}) / $signed({bus[31], bus}));
    assign rem_ext = (bus == 32'd0) ? 33'd0
                   : $unsigned($signed({y[31], y}) % $signed({bus[31], bus}));
    assign sh    = bus[4:0];
    assign rot_r = {y, y} >> sh;
    assign rot_l = {y, y} << sh;

    // ALU operation select, IncPC highest priority, then AND..NOT in order.
    always_comb begin
        alu = 64'd0;
        if (IncPC)    alu = {32'd0, bus + 32'd1};
        else if (AND) alu = {32'd0, y & bus};
        else if (OR)  alu = {32'd0, y | bus};
        else if (ADD) alu = {32'd0, y + bus};
        else if (SUB) alu = {32'd0, y - bus};
        else if (MUL) alu = prod;
        else if (DIV) alu = {rem_ext[31:0], quo_ext[31:0]};
        else if (SHR) alu = {32'd0, y >> sh};
        else if (SHL) alu = {32'd0, y << sh};
        else if (ROR) alu = {32'd0, rot_r[31:0]};
        else if (ROL) alu = {32'd0, rot_l[63:32]};
        else if (NEG) alu = {32'd0, 32'd0 - bus};
        else if (NOT) alu = {32'd0, ~bus};
    end

    // Register file: Clear wins over every load enable.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            pc  <= 32'd0;
            ir  <= 32'd0;
            mar <= 32'd0;
            mdr <= 32'd0;
            y   <= 32'd0;
            z   <= 64'd0;
            hi  <= 32'd0;
            lo  <= 32'd0;
            r2  <= 32'd0;
            r4  <= 32'd0;
            r5  <= 32'd0;
        end else begin
            if (PCin)  pc  <= bus;
            if (IRin)  ir  <= bus;
            if (MARin) mar <= bus;
            if (MDRin) mdr <= Read ? Mdatain : bus;
            if (Yin)   y   <= bus;
            if (Zin)   z   <= alu;
            if (HIin)  hi  <= bus;
            if (LOin)  lo  <= bus;
            if (R2in)  r2  <= bus;
            if (R4in)  r4  <= bus;
            if (R5in)  r5  <= bus;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: strobe-level driver tasks, an expected
// queue filled as stimulus is applied, drained against sampled DUT values.
module tb_datapath;

    logic [31:0] outp;
    logic PCout, Zhiout, Zlowout, MDRout, R2out, R4out, HIout, LOout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
    logic IncPC, Read, R5in, R2in, R4in;
    logic Clock, Clear;
    logic [31:0] Mdatain;
    logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    string       name_q[$];
    int compared   = 0;
    int mismatched = 0;

    localparam int S_PC = 0, S_ZHI = 1, S_ZLO = 2, S_MDR = 3, S_R2 = 4, S_R4 = 5, S_HI = 6, S_LO = 7;
    localparam int O_INC = 0, O_AND = 1, O_OR = 2, O_ADD = 3, O_SUB = 4, O_MUL = 5, O_DIV = 6;
    localparam int O_SHR = 7, O_SHL = 8, O_ROR = 9, O_ROL = 10, O_NEG = 11, O_NOT = 12;

    datapath dut (
        .outp(outp), .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
        .R2out(R2out), .R4out(R4out), .HIout(HIout), .LOout(LOout), .MARin(MARin),
        .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin),
        .LOin(LOin), .IncPC(IncPC), .Read(Read), .R5in(R5in), .R2in(R2in), .R4in(R4in),
        .Clock(Clock), .Clear(Clear), .Mdatain(Mdatain), .AND(AND), .OR(OR), .ADD(ADD),
        .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL),
        .NEG(NEG), .NOT(NOT)
    );

    // Clock
    initial begin
        Clock = 1'b0;
        forever #10 Clock = ~Clock;
    end

    task automatic clear_strobes();
        {PCout, Zhiout, Zlowout, MDRout, R2out, R4out, HIout, LOout} = '0;
        {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin} = '0;
        {IncPC, Read, R5in, R2in, R4in} = '0;
        {AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT} = '0;
    endtask

    // One rising edge, then settle; strobes drop afterwards.
    task automatic step();
        @(posedge Clock);
        #1;
        clear_strobes();
    endtask

    task automatic set_src(input int src);
        case (src)
            S_PC:    PCout   = 1'b1;
            S_ZHI:   Zhiout  = 1'b1;
            S_ZLO:   Zlowout = 1'b1;
            S_MDR:   MDRout  = 1'b1;
            S_R2:    R2out   = 1'b1;
            S_R4:    R4out   = 1'b1;
            S_HI:    HIout   = 1'b1;
            default: LOout   = 1'b1;
        endcase
    endtask

    task automatic set_op(input int op);
        case (op)
            O_INC:   IncPC = 1'b1;
            O_AND:   AND   = 1'b1;
            O_OR:    OR    = 1'b1;
            O_ADD:   ADD   = 1'b1;
            O_SUB:   SUB   = 1'b1;
            O_MUL:   MUL   = 1'b1;
            O_DIV:   DIV   = 1'b1;
            O_SHR:   SHR   = 1'b1;
            O_SHL:   SHL   = 1'b1;
            O_ROR:   ROR   = 1'b1;
            O_ROL:   ROL   = 1'b1;
            O_NEG:   NEG   = 1'b1;
            default: NOT   = 1'b1;
        endcase
    endtask

    // Put one register on the bus mid-cycle and record what outp shows.
    task automatic peek(input int src);
        set_src(src);
        #1;
        got_q.push_back(outp);
        {PCout, Zhiout, Zlowout, MDRout, R2out, R4out, HIout, LOout} = '0;
        #1;
    endtask

    task automatic expect_next(input string nm, input logic [31:0] v);
        name_q.push_back(nm);
        exp_q.push_back(v);
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v;
        Read = 1'b1;
        MDRin = 1'b1;
        step();
    endtask

    // Y <= a, then Z <= op(Y, b) with b driven from MDR.
    task automatic alu_op(input logic [31:0] a, input logic [31:0] b, input int op);
        load_mdr(a);
        MDRout = 1'b1; Yin = 1'b1;
        step();
        load_mdr(b);
        MDRout = 1'b1; set_op(op); Zin = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [31:0] g, e;
        string nm;
        load_mdr(32'hA5A5_A5A5);
        MDRout = 1'b1;
        {MARin, PCin, IRin, Yin, HIin, LOin, R2in, R4in, R5in, ADD, Zin} = '1;
        step();
        Clear = 1'b1;
        {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, R2in, R4in, R5in, Read, IncPC} = '1;
        Mdatain = 32'hFFFF_FFFF;
        PCout = 1'b1;
        step();
        Clear = 1'b0;
        #1;
        expect_next("reset_bus_idle", 32'd0); got_q.push_back(outp);
        for (int s = 0; s < 8; s++) begin
            expect_next($sformatf("reset_src%0d", s), 32'd0);
            peek(s);
        end
        expect_next("reset_ir", 32'd0);  got_q.push_back(dut.ir);
        expect_next("reset_mar", 32'd0); got_q.push_back(dut.mar);
        expect_next("reset_y", 32'd0);   got_q.push_back(dut.y);
        expect_next("reset_r5", 32'd0);  got_q.push_back(dut.r5);
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); nm = name_q.pop_front();
            compared++;
            if (g !== e) begin $display("FAIL %s: got %h expected %h", nm, g, e); mismatched++; end
        end
    endtask

    task automatic test_load();
        logic [31:0] g, e;
        string nm;
        load_mdr(32'd12); MDRout = 1'b1; R2in = 1'b1; step();
        load_mdr(32'd15); MDRout = 1'b1; R4in = 1'b1; step();
        load_mdr(32'd10); MDRout = 1'b1; R5in = 1'b1; step();
        expect_next("load_r2", 32'd12);  peek(S_R2);
        expect_next("load_r4", 32'd15);  peek(S_R4);
        expect_next("load_mdr", 32'd10); peek(S_MDR);
        expect_next("load_r5", 32'd10);  got_q.push_back(dut.r5);
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); nm = name_q.pop_front();
            compared++;
            if (g !== e) begin $display("FAIL %s: got %h expected %h", nm, g, e); mismatched++; end
        end
    endtask

    task automatic test_fetch();
        logic [31:0] g, e;
        string nm;
        load_mdr(32'h55); MDRout = 1'b1; MARin = 1'b1; step();
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; step();
        expect_next("fetch_t0_mar", 32'd0); got_q.push_back(dut.mar);
        expect_next("fetch_t0_zlo", 32'd1); peek(S_ZLO);
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'h1A92_0000; step();
        expect_next("fetch_t1_pc", 32'd1);           peek(S_PC);
        expect_next("fetch_t1_mdr", 32'h1A92_0000);  peek(S_MDR);
        MDRout = 1'b1; IRin = 1'b1; step();
        expect_next("fetch_t2_ir", 32'h1A92_0000);   got_q.push_back(dut.ir);
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); nm = name_q.pop_front();
            compared++;
            if (g !== e) begin $display("FAIL %s: got %h expected %h", nm, g, e); mismatched++; end
        end
    endtask

    task automatic test_or();
        logic [31:0] g, e;
        string nm;
        R2out = 1'b1; Yin = 1'b1; step();
        expect_next("or_y", 32'd12); got_q.push_back(dut.y);
        R4out = 1'b1; OR = 1'b1; Zin = 1'b1; step();
        expect_next("or_zhi", 32'd0);  peek(S_ZHI);
        expect_next("or_zlo", 32'hF);  peek(S_ZLO);
        Zlowout = 1'b1; R5in = 1'b1;
        #1;
        expect_next("or_bus_during_move", 32'd15); got_q.push_back(outp);
        step();
        expect_next("or_r5", 32'd15); got_q.push_back(dut.r5);
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); nm = name_q.pop_front();
            compared++;
            if (g !== e) begin $display("FAIL %s: got %h expected %h", nm, g, e); mismatched++; end
        end
    endtask

    task automatic test_muldiv();
        logic [31:0] g, e;
        string nm;
        alu_op(32'hFFFF_FFFA, 32'd4, O_MUL);
        expect_next("mul_zhi", 32'hFFFF_FFFF); peek(S_ZHI);
        expect_next("mul_zlo", 32'hFFFF_FFE8); peek(S_ZLO);
        alu_op(32'd17, 32'd5, O_DIV);
        expect_next("div_quo", 32'd3); peek(S_ZLO);
        expect_next("div_rem", 32'd2); peek(S_ZHI);
        alu_op(32'hFFFF_FFEF, 32'd5, O_DIV);
        expect_next("div_neg_quo", 32'hFFFF_FFFD); peek(S_ZLO);
        expect_next("div_neg_rem", 32'hFFFF_FFFE); peek(S_ZHI);
        // Y stays -17; no bus source gives a divisor of zero.
        DIV = 1'b1; Zin = 1'b1; step();
        expect_next("div0_zlo", 32'd0); peek(S_ZLO);
        expect_next("div0_zhi", 32'd0); peek(S_ZHI);
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); nm = name_q.pop_front();
            compared++;
            if (g !== e) begin $display("FAIL %s: got %h expected %h", nm, g, e); mismatched++; end
        end
    endtask

    task automatic test_logic_shift();
        logic [31:0] g, e;
        string nm;
        alu_op(32'h8000_0001, 32'd1, O_ROL);
        expect_next("rol", 32'h0000_0003); peek(S_ZLO);
        expect_next("rol_zhi", 32'd0);     peek(S_ZHI);
        alu_op(32'h8000_0001, 32'd1, O_ROR); expect_next("ror", 32'hC000_0000); peek(S_ZLO);
        alu_op(32'h8000_0001, 32'd4, O_SHR); expect_next("shr", 32'h0800_0000); peek(S_ZLO);
        alu_op(32'h8000_0001, 32'd4, O_SHL); expect_next("shl", 32'h0000_0010); peek(S_ZLO);
        alu_op(32'h0000_F0F0, 32'h0000_FF00, O_AND); expect_next("and", 32'h0000_F000); peek(S_ZLO);
        alu_op(32'hFFFF_FFFF, 32'd2, O_ADD); expect_next("add_wrap", 32'd1); peek(S_ZLO);
        alu_op(32'd3, 32'd10, O_SUB);        expect_next("sub_wrap", 32'hFFFF_FFF9); peek(S_ZLO);
        alu_op(32'd0, 32'd5, O_NEG);         expect_next("neg", 32'hFFFF_FFFB); peek(S_ZLO);
        NOT = 1'b1; Zin = 1'b1; step();
        expect_next("not_bus0", 32'hFFFF_FFFF); peek(S_ZLO);
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); nm = name_q.pop_front();
            compared++;
            if (g !== e) begin $display("FAIL %s: got %h expected %h", nm, g, e); mismatched++; end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] g, e;
        string nm;
        logic [31:0] hv, lv, zv;
        hv = $urandom_range(32'h0FFF_FFFF, 32'h1000);
        lv = hv ^ 32'hF0F0_0000;
        load_mdr(hv); MDRout = 1'b1; HIin = 1'b1; step();
        load_mdr(lv); MDRout = 1'b1; LOin = 1'b1; step();
        expect_next("hi", hv); peek(S_HI);
        expect_next("lo", lv); peek(S_LO);
        HIout = 1'b1; LOout = 1'b1; #1;
        expect_next("prio_hi_over_lo", hv); got_q.push_back(outp);
        PCout = 1'b1; MDRout = 1'b1; #1;
        expect_next("prio_pc_over_all", 32'd1); got_q.push_back(outp);
        clear_strobes();
        // IncPC outranks ADD: result is bus+1, not Y+bus.
        alu_op(32'd7, lv, O_ADD);
        MDRout = 1'b1; IncPC = 1'b1; ADD = 1'b1; Zin = 1'b1; step();
        zv = lv + 32'd1;
        expect_next("incpc_over_add", zv); peek(S_ZLO);
        Zlowout = 1'b1; R2out = 1'b1; #1;
        expect_next("prio_zlo_over_r2", zv); got_q.push_back(outp);
        clear_strobes();
        for (int i = 0; i < 3; i++) begin
            Zlowout = 1'b1; IncPC = 1'b1; Zin = 1'b1; step();
            zv = zv + 32'd1;
            expect_next($sformatf("z_self_inc%0d", i), zv); peek(S_ZLO);
        end
        Clear = 1'b1; step(); Clear = 1'b0;
        expect_next("clear_again_zlo", 32'd0); peek(S_ZLO);
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); nm = name_q.pop_front();
            compared++;
            if (g !== e) begin $display("FAIL %s: got %h expected %h", nm, g, e); mismatched++; end
        end
    endtask

    // Reset, sequence of scenarios, report.
    initial begin
        clear_strobes();
        Mdatain = 32'd0;
        Clear = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        Clear = 1'b0;
        test_reset();
        test_load();
        test_fetch();
        test_or();
        test_muldiv();
        test_logic_shift();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
            mismatched++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
